// File: rtl/mem_d_responder.sv
// Data-memory responder for the RV64 data port: word-addressed 64-bit store
// with fixed request-to-ready latency. Define MEM_D_ERR_EN to add mem_err_D.
module mem_d_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_D,
    input  logic        mem_wen_D,
    input  logic [31:2] mem_addr_D,
    input  logic [63:0] mem_wdata_D,
    output logic [63:0] mem_rdata_D,
`ifdef MEM_D_ERR_EN
    output logic        mem_err_D,
`endif
    output logic        mem_ready_D
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                wen_q;
    logic                oor_q;
    logic [63:0]         wdata_q;
    logic [63:0]         rdata_q;
    logic                ready_q;
    logic                err_q;
    logic [63:0]         mem_q [DEPTH];

    logic                req_oor;
    logic [63:0]         rd_word_d;

    assign req_oor = |mem_addr_D[31:ADDR_W+2];

    // Word seen by a read in RESP; out-of-range reads return zero.
    always_comb begin
        rd_word_d = '0;
        if (!oor_q) begin
            rd_word_d = mem_q[idx_q];
        end
    end

    // Read data is live during a read's RESP cycle, otherwise the last read.
    assign mem_rdata_D = (state_q == RESP && !wen_q) ? rd_word_d : rdata_q;
    assign mem_ready_D = ready_q;
`ifdef MEM_D_ERR_EN
    assign mem_err_D   = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

    // Request FSM: capture in IDLE, count down in WAIT, respond in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_req_D) begin
                        idx_q   <= mem_addr_D[ADDR_W+1:2];
                        wen_q   <= mem_wen_D;
                        oor_q   <= req_oor;
                        wdata_q <= mem_wdata_D;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= req_oor;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= oor_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (!wen_q) begin
                        rdata_q <= rd_word_d;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage: cleared on reset, written at the end of a write's RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == RESP && wen_q && !oor_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_d_responder.sv
// Randomized self-checking bench for mem_d_responder against an array model.
// Also runs held-request latency sweeps on LATENCY=1 and LATENCY=4 copies.
module tb_mem_d_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic [29:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic        ready;
    logic        sw_req = 1'b0;
    logic [63:0] rdata1, rdata4;
    logic        ready1, ready4;
`ifdef MEM_D_ERR_EN
    logic        err, err1, err4;
`endif

    int checks = 0;
    int failures = 0;

    logic [63:0] model [256];
    logic [63:0] last_rd;

    always #5 clk = ~clk;

    mem_d_responder #(.ADDR_W(8), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .mem_req_D(req), .mem_wen_D(wen),
        .mem_addr_D(addr), .mem_wdata_D(wdata), .mem_rdata_D(rdata),
`ifdef MEM_D_ERR_EN
        .mem_err_D(err),
`endif
        .mem_ready_D(ready));

    mem_d_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_req_D(sw_req), .mem_wen_D(1'b0),
        .mem_addr_D(30'h0), .mem_wdata_D(64'h0), .mem_rdata_D(rdata1),
`ifdef MEM_D_ERR_EN
        .mem_err_D(err1),
`endif
        .mem_ready_D(ready1));

    mem_d_responder #(.ADDR_W(8), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .mem_req_D(sw_req), .mem_wen_D(1'b0),
        .mem_addr_D(30'h0), .mem_wdata_D(64'h0), .mem_rdata_D(rdata4),
`ifdef MEM_D_ERR_EN
        .mem_err_D(err4),
`endif
        .mem_ready_D(ready4));

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = '0;
        last_rd = '0;
    endtask

    // One transaction; busy=1 scrambles inputs while the request is in flight.
    task automatic txn(input bit w, input logic [29:0] a, input logic [63:0] d,
                       input bit busy, input string tag);
        bit          oor;
        int          lat;
        logic [63:0] exp_rd;
        oor = (a >> 8) != 0;
        exp_rd = w ? last_rd : (oor ? 64'h0 : model[a & 30'hFF]);
        @(negedge clk);
        req = 1'b1; wen = w; addr = a; wdata = d;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req = 1'b0;
                if (busy) begin
                    addr = 30'h7;
                    wen = ~wen;
                    wdata = {$urandom, $urandom};
                end
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        if (lat != 0) begin
            check({tag, "_rdata"}, rdata, exp_rd);
`ifdef MEM_D_ERR_EN
            check({tag, "_err"}, 64'(err), 64'(oor));
`endif
        end
        if (w && !oor) model[a & 30'hFF] = d;
        if (!w) last_rd = exp_rd;
        @(negedge clk);
        check({tag, "_rdy_low"}, 64'(ready), 64'h0);
        check({tag, "_hold"}, rdata, last_rd);
`ifdef MEM_D_ERR_EN
        check({tag, "_err_low"}, 64'(err), 64'h0);
`endif
    endtask

    initial begin
        int p1 [$];
        int p4 [$];
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_rdata", rdata, 64'h0);
        rst = 1'b0;

        txn(1'b0, 30'h10, 64'h0, 1'b0, "rd_after_rst");
        txn(1'b1, 30'h05, 64'hDEADBEEF_01234567, 1'b0, "wr05");
        txn(1'b0, 30'h05, 64'h0, 1'b0, "rd05");
        txn(1'b0, 30'h06, 64'h0, 1'b0, "rd06");
        txn(1'b0, 30'h05, 64'h0, 1'b1, "busy_rd05");
        txn(1'b0, 30'h07, 64'h0, 1'b0, "rd07");
        txn(1'b1, 30'h100, 64'h1, 1'b0, "wr_oor");
        txn(1'b0, 30'h100, 64'h0, 1'b0, "rd_oor");
        txn(1'b0, 30'h00, 64'h0, 1'b0, "rd00");

        // Reset lands while the write is in WAIT.
        txn(1'b1, 30'h03, 64'h55, 1'b0, "wr03_pre");
        @(negedge clk);
        req = 1'b1; wen = 1'b1; addr = 30'h03; wdata = 64'hAA;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        model_clear();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("midrst_ready", 64'(ready), 64'h0);
        end
        check("midrst_rdata", rdata, 64'h0);
        rst = 1'b0;
        txn(1'b0, 30'h03, 64'h0, 1'b0, "rd03_post_rst");

        for (int k = 0; k < 40; k++) begin
            int r;
            logic [29:0] a;
            r = $urandom_range(0, 9);
            if (r < 7) a = 30'($urandom_range(0, 15));
            else if (r < 9) a = 30'($urandom_range(0, 255));
            else a = 30'($urandom) | 30'h100;
            txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                1'($urandom_range(0, 1)), "rand");
        end

        // Held request on the LATENCY=1 and LATENCY=4 copies.
        @(negedge clk);
        sw_req = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready1) p1.push_back(n);
            if (ready4) p4.push_back(n);
        end
        sw_req = 1'b0;
        check("sw1_count", 64'(p1.size()), 64'd20);
        check("sw4_count", 64'(p4.size()), 64'd8);
        if (p1.size() > 0) check("sw1_first", 64'(p1[0]), 64'd1);
        if (p4.size() > 0) check("sw4_first", 64'(p4[0]), 64'd4);
        for (int i = 1; i < p1.size(); i++)
            check("sw1_gap", 64'(p1[i] - p1[i-1]), 64'd2);
        for (int i = 1; i < p4.size(); i++)
            check("sw4_gap", 64'(p4[i] - p4[i-1]), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
